// File: rtl/game_ctrl.sv
//============================================================================
// game_ctrl : IDLE/RUNNING/OVER sequencer for the dinosaur runner; owns the
//             BCD score, the high score, the scroll speed and jump requests.
// Revision  : 1.0
//============================================================================
`default_nettype none

module game_ctrl #(
    parameter int SCORE_FRAMES = 6,
    parameter int SPEED_STEP   = 100,
    parameter int SPEED_INIT   = 1,
    parameter int SPEED_MAX    = 15,
    parameter int OVER_HOLD    = 60
) (
    input  logic        CLK,
    input  logic        clrn,
    input  logic        btn_jump,
    input  logic        frame_tick,
    input  logic        collision,
    output logic        game_status,
    output logic [3:0]  speed,
    output logic        jump_req,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [1:0]  state
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_RUNNING = 2'b01;
    localparam logic [1:0] S_OVER    = 2'b10;

    localparam int FW = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
    localparam int SW = (SPEED_STEP > 1)   ? $clog2(SPEED_STEP)   : 1;
    localparam int HW = (OVER_HOLD > 0)    ? $clog2(OVER_HOLD + 1) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(SCORE_FRAMES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(SPEED_STEP - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(OVER_HOLD);
    localparam logic [3:0]    SPD_INIT   = 4'(SPEED_INIT);
    localparam logic [3:0]    SPD_MAX    = 4'(SPEED_MAX);
    localparam logic [15:0]   SCORE_SAT  = 16'h9999;

    logic [1:0]    state_q, state_d;
    logic          status_q, status_d;
    logic [3:0]    speed_q, speed_d;
    logic          jump_q, jump_d;
    logic [15:0]   score_q, score_d;
    logic [15:0]   high_q, high_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          btn_q;
    logic          press;

    assign press = btn_jump & ~btn_q;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        jump_d      = 1'b0;
        score_d     = score_q;
        high_d      = high_q;
        frame_cnt_d = frame_cnt_q;
        step_cnt_d  = step_cnt_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d     = S_RUNNING;
                    score_d     = 16'h0000;
                    frame_cnt_d = '0;
                    step_cnt_d  = '0;
                    speed_d     = SPD_INIT;
                end
            end
            S_RUNNING: begin
                if (collision) begin
                    state_d    = S_OVER;
                    hold_cnt_d = '0;
                    // Valid BCD orders the same as binary, so a plain compare is MSD-first.
                    if (score_q > high_q) begin
                        high_d = score_q;
                    end
                end else begin
                    jump_d = press;
                    if (frame_tick) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d = '0;
                            if (score_q != SCORE_SAT) begin
                                score_d = bcd_inc(score_q);
                                if (step_cnt_q == STEP_LAST) begin
                                    step_cnt_d = '0;
                                    if (speed_q < SPD_MAX) begin
                                        speed_d = speed_q + 4'd1;
                                    end
                                end else begin
                                    step_cnt_d = step_cnt_q + SW'(1);
                                end
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                        end
                    end
                end
            end
            S_OVER: begin
                if (frame_tick && (hold_cnt_q < HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
                if (press && (hold_cnt_q == HOLD_MAX)) begin
                    state_d     = S_RUNNING;
                    score_d     = 16'h0000;
                    frame_cnt_d = '0;
                    step_cnt_d  = '0;
                    speed_d     = SPD_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        status_d = (state_d == S_RUNNING);
    end

    // btn_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            status_q    <= 1'b0;
            speed_q     <= SPD_INIT;
            jump_q      <= 1'b0;
            score_q     <= 16'h0000;
            high_q      <= 16'h0000;
            frame_cnt_q <= '0;
            step_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            btn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            speed_q     <= speed_d;
            jump_q      <= jump_d;
            score_q     <= score_d;
            high_q      <= high_d;
            frame_cnt_q <= frame_cnt_d;
            step_cnt_q  <= step_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            btn_q       <= btn_jump;
        end
    end

    assign game_status = status_q;
    assign speed       = speed_q;
    assign jump_req    = jump_q;
    assign score       = score_q;
    assign high_score  = high_q;
    assign state       = state_q;

endmodule

`default_nettype wire
